// File: rtl/debounce_conditioner.sv
// Debounce conditioner: synchronizes a raw asynchronous level, accepts a new
// level only after STABLE_CYCLES consecutive equal samples, emits one-cycle
// rise/fall pulses on the cleaned level and counts rejected level changes.
module debounce_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_raw,
    input  logic       glitch_clr,
    output logic       a_clean,
    output logic       rise,
    output logic       fall,
    output logic [7:0] glitch_cnt
);

    localparam int            CW     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST   = CW'(STABLE_CYCLES - 1);
    localparam bit            DIRECT = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        CHECK_HIGH,
        STABLE_HIGH,
        CHECK_LOW
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_nextCnt;
    logic                   r_clean;
    logic                   w_nextClean;
    logic                   w_glitch;
    logic                   w_s;
    logic                   r_rise;
    logic                   r_fall;
    logic [7:0]             r_glitchCnt;

    // Synchronizer chain; only its last stage is seen by the rest of the block.
    always_ff @(posedge clk) begin
        if (rst)
            r_sync <= '0;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], a_raw};
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Next-state logic: count consecutive samples that differ from the accepted level.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextClean = r_clean;
        w_glitch    = 1'b0;
        case (r_state)
            STABLE_LOW: begin
                if (w_s) begin
                    if (DIRECT) begin
                        w_nextState = STABLE_HIGH;
                        w_nextClean = 1'b1;
                        w_nextCnt   = '0;
                    end else begin
                        w_nextState = CHECK_HIGH;
                        w_nextCnt   = CW'(1);
                    end
                end
            end
            CHECK_HIGH: begin
                if (!w_s) begin
                    w_nextState = STABLE_LOW;
                    w_nextCnt   = '0;
                    w_glitch    = 1'b1;
                end else if (r_cnt == LAST) begin
                    w_nextState = STABLE_HIGH;
                    w_nextClean = 1'b1;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!w_s) begin
                    if (DIRECT) begin
                        w_nextState = STABLE_LOW;
                        w_nextClean = 1'b0;
                        w_nextCnt   = '0;
                    end else begin
                        w_nextState = CHECK_LOW;
                        w_nextCnt   = CW'(1);
                    end
                end
            end
            CHECK_LOW: begin
                if (w_s) begin
                    w_nextState = STABLE_HIGH;
                    w_nextCnt   = '0;
                    w_glitch    = 1'b1;
                end else if (r_cnt == LAST) begin
                    w_nextState = STABLE_LOW;
                    w_nextClean = 1'b0;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nextState = STABLE_LOW;
                w_nextCnt   = '0;
                w_nextClean = 1'b0;
            end
        endcase
    end

    // State register; pulses are registered with the level so they align with its change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_clean <= w_nextClean;
            r_rise  <= w_nextClean & ~r_clean;
            r_fall  <= ~w_nextClean & r_clean;
        end
    end

    // Saturating glitch counter; clear takes priority over a coincident glitch.
    always_ff @(posedge clk) begin
        if (rst || glitch_clr)
            r_glitchCnt <= 8'd0;
        else if (w_glitch && (r_glitchCnt != 8'hFF))
            r_glitchCnt <= r_glitchCnt + 8'd1;
    end

    assign a_clean    = r_clean;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign glitch_cnt = r_glitchCnt;

endmodule

// File: tb/tb_debounce_conditioner.sv
// Testbench for debounce_conditioner: two instances (STABLE_CYCLES 4 and 1)
// share stimulus; a run-length reference model feeds a scoreboard queue.
module tb_debounce_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_raw = 1'b0;
    logic       glitch_clr = 1'b0;
    logic       clean0, rise0, fall0, clean1, rise1, fall1;
    logic [7:0] gcnt0, gcnt1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       c0;
        logic       r0;
        logic       f0;
        logic [7:0] g0;
        logic       c1;
        logic       r1;
        logic       f1;
        logic [7:0] g1;
    } expect_t;

    expect_t scoreboard[$];

    int   sc[2] = '{4, 1};
    logic mSync0 = 1'b0;
    logic mSync1 = 1'b0;
    logic mClean[2];
    logic mRise[2];
    logic mFall[2];
    int   mRun[2];
    int   mGcnt[2];

    // Free-running clock
    always #5 clk = ~clk;

    debounce_conditioner #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .a_raw(a_raw), .glitch_clr(glitch_clr),
        .a_clean(clean0), .rise(rise0), .fall(fall0), .glitch_cnt(gcnt0)
    );

    debounce_conditioner #(.SYNC_STAGES(2), .STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .a_raw(a_raw), .glitch_clr(glitch_clr),
        .a_clean(clean1), .rise(rise1), .fall(fall1), .glitch_cnt(gcnt1)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model: a level flips once the run of samples differing from it reaches sc.
    task automatic modelStep();
        logic    s;
        logic    nc;
        logic    g;
        expect_t e;
        if (rst) begin
            mSync0 = 1'b0;
            mSync1 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                mClean[i] = 1'b0;
                mRise[i]  = 1'b0;
                mFall[i]  = 1'b0;
                mRun[i]   = 0;
                mGcnt[i]  = 0;
            end
        end else begin
            s      = mSync1;
            mSync1 = mSync0;
            mSync0 = a_raw;
            for (int i = 0; i < 2; i++) begin
                g  = 1'b0;
                nc = mClean[i];
                if (s != mClean[i]) begin
                    mRun[i]++;
                    if (mRun[i] >= sc[i]) begin
                        nc      = s;
                        mRun[i] = 0;
                    end
                end else begin
                    if (mRun[i] > 0) g = 1'b1;
                    mRun[i] = 0;
                end
                mRise[i]  = nc & ~mClean[i];
                mFall[i]  = ~nc & mClean[i];
                mClean[i] = nc;
                if (glitch_clr)
                    mGcnt[i] = 0;
                else if (g && mGcnt[i] < 255)
                    mGcnt[i]++;
            end
        end
        e.c0 = mClean[0]; e.r0 = mRise[0]; e.f0 = mFall[0]; e.g0 = 8'(mGcnt[0]);
        e.c1 = mClean[1]; e.r1 = mRise[1]; e.f1 = mFall[1]; e.g1 = 8'(mGcnt[1]);
        scoreboard.push_back(e);
    endtask

    // Model advances on every active edge, pushing the expected outputs
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Compare DUT outputs against the scoreboard on the opposite edge
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                checkOutput("sb_clean0", 8'(clean0), 8'(e.c0));
                checkOutput("sb_rise0",  8'(rise0),  8'(e.r0));
                checkOutput("sb_fall0",  8'(fall0),  8'(e.f0));
                checkOutput("sb_gcnt0",  gcnt0,      e.g0);
                checkOutput("sb_clean1", 8'(clean1), 8'(e.c1));
                checkOutput("sb_rise1",  8'(rise1),  8'(e.r1));
                checkOutput("sb_fall1",  8'(fall1),  8'(e.f1));
                checkOutput("sb_gcnt1",  gcnt1,      e.g1);
            end
        end
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic rawV, input logic clrV, input logic rstV, input int cycles);
        a_raw      = rawV;
        glitch_clr = clrV;
        rst        = rstV;
        repeat (cycles) @(negedge clk);
    endtask

    // Directed scenarios; the scoreboard checks every cycle alongside them
    initial begin
        int nRise;
        int nFall;
        int nHigh;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 3);

        // Full latency rise: visible after edge 5
        applyStimulus(1'b1, 1'b0, 1'b0, 5);
        checkOutput("lat_clean_e4", 8'(clean0), 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("lat_clean_e5", 8'(clean0), 8'd1);
        checkOutput("lat_rise_e5",  8'(rise0),  8'd1);
        checkOutput("lat_gcnt",     gcnt0,      8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("lat_rise_e6",  8'(rise0),  8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4);

        // Short low dip is rejected as one glitch
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 8);
        checkOutput("dip_clean", 8'(clean0), 8'd1);
        checkOutput("dip_gcnt",  gcnt0,      8'd1);

        // Toggle every cycle: 20 dips plus the first one
        for (int i = 0; i < 40; i++) applyStimulus(i[0], 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8);
        checkOutput("tog_clean", 8'(clean0), 8'd1);
        checkOutput("tog_gcnt",  gcnt0,      8'd21);

        // Drive well past 255 glitches to check saturation
        for (int i = 0; i < 520; i++) applyStimulus(i[0], 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 6);
        checkOutput("sat_gcnt", gcnt0, 8'd255);

        // Clear held while glitches keep occurring
        for (int i = 0; i < 6; i++) applyStimulus(i[0], 1'b1, 1'b0, 1);
        checkOutput("clr_gcnt", gcnt0, 8'd0);
        for (int i = 0; i < 4; i++) applyStimulus(i[0], 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 6);

        // Single-cycle pulse on the STABLE_CYCLES=1 instance
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        a_raw = 1'b0;
        nRise = 0;
        nFall = 0;
        nHigh = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            nRise += int'(rise1);
            nFall += int'(fall1);
            nHigh += int'(clean1);
        end
        checkOutput("pulse_rise",  8'(nRise), 8'd1);
        checkOutput("pulse_fall",  8'(nFall), 8'd1);
        checkOutput("pulse_high",  8'(nHigh), 8'd1);
        checkOutput("pulse_clean0", 8'(clean0), 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 6);

        // Reset in the middle of CHECK_HIGH (cnt=2), with clear also high
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        checkOutput("pre_rst_clean1", 8'(clean1), 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("rst_clean0", 8'(clean0), 8'd0);
        checkOutput("rst_rise0",  8'(rise0),  8'd0);
        checkOutput("rst_fall0",  8'(fall0),  8'd0);
        checkOutput("rst_gcnt0",  gcnt0,      8'd0);
        checkOutput("rst_fall1",  8'(fall1),  8'd0);
        checkOutput("rst_clean1", 8'(clean1), 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);

        // Release with input held high: full latency again
        applyStimulus(1'b1, 1'b0, 1'b0, 5);
        checkOutput("rel_clean_e4", 8'(clean0), 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("rel_clean_e5", 8'(clean0), 8'd1);
        checkOutput("rel_rise_e5",  8'(rise0),  8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("rel_rise_e6",  8'(rise0),  8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
